dcache_write_buffer: RTL and testbench

//  Store buffer downstream of the write-through data cache, upstream of the AXI write channels.

---
 rtl/dcache_write_buffer.sv | 155 +++++++++++++++
 tb/tb_dcache_write_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_write_buffer.sv
// In-order store buffer between the write-through D-cache and the AXI AW/W/B channels.
// One outstanding AXI transaction; the head entry is held (and conflict-checked) until its B.
module dcache_write_buffer #(
   parameter int         DEPTH  = 8,
   parameter logic [3:0] AXI_ID = 4'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [31:0] s_addr,
   input  logic [31:0] s_data,
   input  logic [3:0]  s_strb,
   input  logic        s_uncached,
   input  logic [31:0] q_addr,
   output logic        q_conflict,
   output logic        empty,
   output logic        full,
   output logic [3:0]  m_awid,
   output logic [31:0] m_awaddr,
   output logic [7:0]  m_awlen,
   output logic [2:0]  m_awsize,
   output logic [1:0]  m_awburst,
   output logic        m_awvalid,
   input  logic        m_awready,
   output logic [3:0]  m_wid,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        m_wlast,
   output logic        m_wvalid,
   input  logic        m_wready,
   input  logic        m_bvalid,
   output logic        m_bready
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_t;

   state_t           r_state;
   logic [31:0]      r_addr [DEPTH];
   logic [31:0]      r_data [DEPTH];
   logic [3:0]       r_strb [DEPTH];
   logic             r_unc  [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [AW-1:0]    r_head, r_tail;
   logic [AW:0]      r_count;
   logic             r_aw_done, r_w_done;

   logic w_push, w_pop, w_aw_hs, w_w_hs;
   logic [31:0] w_hd_addr;
   logic [3:0]  w_hd_strb;
   logic        w_hd_unc;
   logic        w_unused_qlsb;

   assign full    = (r_count == FULL_CNT);
   assign s_ready = !full;
   assign empty   = (r_count == '0) && (r_state == IDLE);
   // zero-strobe stores are acknowledged but never occupy an entry
   assign w_push  = s_valid && s_ready && (s_strb != 4'b0000);
   assign w_pop   = (r_state == WAIT_B) && m_bvalid;
   assign w_aw_hs = m_awvalid && m_awready;
   assign w_w_hs  = m_wvalid && m_wready;

   assign w_hd_addr = r_addr[r_head];
   assign w_hd_strb = r_strb[r_head];
   assign w_hd_unc  = r_unc[r_head];

   assign m_awid    = AXI_ID;
   assign m_wid     = AXI_ID;
   assign m_awlen   = 8'd0;
   assign m_awburst = 2'b01;
   assign m_wlast   = 1'b1;
   assign m_bready  = 1'b1;
   assign m_wdata   = r_data[r_head];
   assign m_wstrb   = w_hd_strb;
   assign w_unused_qlsb = ^q_addr[1:0];

   // Uncached stores keep their byte address and use the narrowest size that covers the strobes
   always_comb begin
      m_awaddr = {w_hd_addr[31:2], 2'b00};
      m_awsize = 3'b010;
      if (w_hd_unc) begin
         m_awaddr = w_hd_addr;
         case (w_hd_strb)
            4'b0011, 4'b1100:                   m_awsize = 3'b001;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: m_awsize = 3'b000;
            default:                            m_awsize = 3'b010;
         endcase
      end
   end

   always_comb begin
      q_conflict = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (r_vld[i] && (r_addr[i][31:2] == q_addr[31:2])) q_conflict = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_tail] <= s_addr;
         r_data[r_tail] <= s_data;
         r_strb[r_tail] <= s_strb;
         r_unc[r_tail]  <= s_uncached;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld     <= '0;
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_state   <= IDLE;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         m_awvalid <= 1'b0;
         m_wvalid  <= 1'b0;
      end else begin
         if (w_push) begin
            r_vld[r_tail] <= 1'b1;
            r_tail        <= r_tail + 1'b1;
         end
         if (w_pop) begin
            r_vld[r_head] <= 1'b0;
            r_head        <= r_head + 1'b1;
         end
         r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
         case (r_state)
            IDLE: if (r_count != '0) begin
               r_state   <= SEND;
               m_awvalid <= 1'b1;
               m_wvalid  <= 1'b1;
            end
            SEND: begin
               if (w_aw_hs) begin
                  m_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (w_w_hs) begin
                  m_wvalid <= 1'b0;
                  r_w_done <= 1'b1;
               end
               if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) r_state <= WAIT_B;
            end
            WAIT_B: if (m_bvalid) begin
               r_state   <= IDLE;
               r_aw_done <= 1'b0;
               r_w_done  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_write_buffer.sv
// Scoreboard bench for dcache_write_buffer: stimulus queues expected AW/W beats,
// a negedge monitor pops and compares on every handshake.
module tb_dcache_write_buffer;
   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid, s_ready, s_uncached;
   logic [31:0] s_addr, s_data, q_addr;
   logic [3:0]  s_strb;
   logic        q_conflict, empty, full;
   logic [3:0]  m_awid, m_wid, m_wstrb;
   logic [31:0] m_awaddr, m_wdata;
   logic [7:0]  m_awlen;
   logic [2:0]  m_awsize;
   logic [1:0]  m_awburst;
   logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

   typedef struct { logic [31:0] a; logic [2:0] s; } aw_t;
   typedef struct { logic [31:0] d; logic [3:0] st; } w_t;
   aw_t aw_q[$];
   w_t  w_q[$];

   int n_cmp = 0, n_err = 0;
   int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   bit b_auto = 1'b1;
   int b_delay = 0;

   always #5 clk = ~clk;

   dcache_write_buffer #(.DEPTH(8), .AXI_ID(4'd1)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
      .s_data(s_data), .s_strb(s_strb), .s_uncached(s_uncached), .q_addr(q_addr),
      .q_conflict(q_conflict), .empty(empty), .full(full),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bready(m_bready));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                        input logic u, input logic [31:0] ea, input logic [2:0] es);
      int n = 0;
      if (st != 4'b0000) begin
         aw_q.push_back('{ea, es});
         w_q.push_back('{d, st});
      end
      s_valid = 1'b1; s_addr = a; s_data = d; s_strb = st; s_uncached = u;
      while (!s_ready && n < 300) begin tick(); n++; end
      chk("s_ready_wait", {31'd0, s_ready}, 32'd1);
      tick();
      s_valid = 1'b0;
   endtask

   task automatic wait_empty(input string nm);
      int n = 0;
      while (!empty && n < 300) begin tick(); n++; end
      chk(nm, {31'd0, empty}, 32'd1);
   endtask

   task automatic wait_hs(input string nm);
      int n = 0;
      while (!(aw_cnt == b_cnt + 1 && w_cnt == b_cnt + 1) && n < 300) begin tick(); n++; end
      chk(nm, w_cnt, b_cnt + 1);
   endtask

   task automatic qchk(input string nm, input logic [31:0] a, input logic exp);
      q_addr = a;
      #1;
      chk(nm, {31'd0, q_conflict}, {31'd0, exp});
   endtask

   // Monitor: every AW/W handshake must match the next expected beat
   always @(negedge clk) begin
      aw_t ea;
      w_t  ew;
      if (!rst && m_awvalid && m_awready) begin
         aw_cnt++;
         if (aw_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL aw_extra: got AW beat addr %h want none", m_awaddr);
         end else begin
            ea = aw_q.pop_front();
            chk("awaddr", m_awaddr, ea.a);
            chk("awsize", {29'd0, m_awsize}, {29'd0, ea.s});
            chk("awlen_burst_id", {18'd0, m_awlen, m_awburst, m_awid}, {18'd0, 8'd0, 2'b01, 4'd1});
         end
      end
      if (!rst && m_wvalid && m_wready) begin
         w_cnt++;
         if (w_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL w_extra: got W beat data %h want none", m_wdata);
         end else begin
            ew = w_q.pop_front();
            chk("wdata", m_wdata, ew.d);
            chk("wstrb_last_id", {23'd0, m_wstrb, m_wlast, m_wid}, {23'd0, ew.st, 1'b1, 4'd1});
         end
      end
   end

   // Auto B responder: one B per completed AW+W pair, after b_delay cycles
   initial forever begin
      tick();
      if (b_auto && aw_cnt > b_cnt && w_cnt > b_cnt) begin
         repeat (b_delay) tick();
         m_bvalid = 1'b1;
         tick();
         m_bvalid = 1'b0;
         b_cnt++;
      end
   end

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_addr = '0; s_data = '0; s_strb = '0; s_uncached = 1'b0;
      q_addr = '0; m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_valids", {30'd0, m_awvalid, m_wvalid}, 32'd0);
      chk("rst_empty_full_rdy", {29'd0, empty, full, s_ready}, {29'd0, 3'b101});

      // 1) single cached word store, latency and drain
      store(32'h1000_0004, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h1000_0004, 3'b010);
      chk("t1_awvalid_cycN", {31'd0, m_awvalid}, 32'd0);
      chk("t1_not_empty", {31'd0, empty}, 32'd0);
      tick();
      chk("t1_awvalid_cycN1", {31'd0, m_awvalid}, 32'd1);
      wait_empty("t1_empty");

      // 2) uncached sizes, cached alignment, zero-strobe discard
      store(32'hBFAF_8002, 32'h00AB_0000, 4'b0100, 1'b1, 32'hBFAF_8002, 3'b000);
      store(32'hBFAF_8002, 32'hABCD_0000, 4'b1100, 1'b1, 32'hBFAF_8002, 3'b001);
      store(32'hBFAF_8000, 32'h00FF_00FF, 4'b0101, 1'b1, 32'hBFAF_8000, 3'b010);
      store(32'h2000_0003, 32'h7700_0000, 4'b1000, 1'b0, 32'h2000_0000, 3'b010);
      wait_empty("t2_empty");
      store(32'h7000_0000, 32'h1234_5678, 4'b0000, 1'b0, 32'h0, 3'b000);
      repeat (4) tick();
      chk("t2_zero_strb_empty", {31'd0, empty}, 32'd1);

      // 3) fill while AW is blocked, then drain in order
      m_awready = 1'b0;
      for (int i = 0; i < 8; i++)
         store(32'h3000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'b1111, 1'b0,
               32'h3000_0000 + 32'(i * 4), 3'b010);
      chk("t3_full_rdy", {30'd0, full, s_ready}, {30'd0, 2'b10});
      m_awready = 1'b1;
      wait_empty("t3_drain");
      chk("t3_aw_q_left", aw_q.size(), 32'd0);

      // 4) load conflict against a pending store
      m_awready = 1'b0;
      store(32'h1000_0008, 32'h0000_0088, 4'b1111, 1'b0, 32'h1000_0008, 3'b010);
      qchk("t4_conf_0B", 32'h1000_000B, 1'b1);
      qchk("t4_conf_0C", 32'h1000_000C, 1'b0);
      m_awready = 1'b1;
      wait_empty("t4_empty");
      qchk("t4_conf_after_b", 32'h1000_000B, 1'b0);

      // 5a) W completes before AW, B after 5 cycles
      b_delay = 5;
      m_awready = 1'b0;
      store(32'h4000_0000, 32'h0000_0044, 4'b1111, 1'b0, 32'h4000_0000, 3'b010);
      repeat (3) tick();
      chk("t5_w_first", {30'd0, m_awvalid, m_wvalid}, {30'd0, 2'b10});
      m_awready = 1'b1;
      wait_empty("t5a_empty");

      // 5b) same-cycle AW+W, then enqueue on the B/pop cycle
      b_auto = 1'b0;
      store(32'h5000_0000, 32'h0000_0055, 4'b1111, 1'b0, 32'h5000_0000, 3'b010);
      wait_hs("t5b_hs");
      repeat (4) tick();
      chk("t5b_waitb", {29'd0, m_awvalid, m_wvalid, empty}, 32'd0);
      m_bvalid = 1'b1;
      store(32'h5000_0040, 32'h0000_0066, 4'b1111, 1'b0, 32'h5000_0040, 3'b010);
      m_bvalid = 1'b0;
      b_cnt++;
      qchk("t5b_popped", 32'h5000_0000, 1'b0);
      qchk("t5b_pushed", 32'h5000_0040, 1'b1);
      chk("t5b_count1", {30'd0, empty, full}, 32'd0);
      b_delay = 0;
      b_auto = 1'b1;
      wait_empty("t5b_empty");

      // 6) reset while waiting for B, then a late B
      b_auto = 1'b0;
      store(32'h6000_0000, 32'h0000_0077, 4'b1111, 1'b0, 32'h6000_0000, 3'b010);
      store(32'h6000_0010, 32'h0000_0078, 4'b1111, 1'b0, 32'h6000_0010, 3'b010);
      wait_hs("t6_hs");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      aw_q.delete();
      w_q.delete();
      chk("t6_rst_valids", {30'd0, m_awvalid, m_wvalid}, 32'd0);
      chk("t6_rst_empty", {31'd0, empty}, 32'd1);
      m_bvalid = 1'b1;
      tick();
      m_bvalid = 1'b0;
      b_cnt++;
      repeat (5) tick();
      chk("t6_late_b", {29'd0, m_awvalid, m_wvalid, empty}, 32'd1);
      qchk("t6_lost_entry", 32'h6000_0010, 1'b0);

      chk("beats_balanced", aw_cnt, w_cnt);
      chk("w_q_left", w_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end
endmodule
